mdu_unit: RTL and testbench

//  Multi-cycle multiply/divide unit for the MIPS core's EX stage; owns the HI/LO registers.

---
 rtl/mdu_unit_pkg.sv | 30 +++
 rtl/mdu_unit_if.sv | 16 +
 rtl/mdu_unit.sv | 137 +++++++++++++
 tb/tb_mdu_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and small helpers.
// Op codes are shared with the ID-stage decoder.
package mdu_unit_pkg;

   typedef enum logic [3:0] {
      MDU_NOP   = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MTHI  = 4'd5,
      MDU_MTLO  = 4'd6,
      MDU_MADD  = 4'd7,
      MDU_MADDU = 4'd8,
      MDU_MSUB  = 4'd9,
      MDU_MSUBU = 4'd10
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   localparam int MDU_CNT_W = 4;

   function automatic logic [63:0] sext64(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Issue/result bundle between the EX stage (master) and the multiply/divide unit (slave).
interface mdu_unit_if;
   import mdu_unit_pkg::*;

   logic        start;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, a, b, input busy, hi, lo);
   modport slave  (input start, op, a, b, output busy, hi, lo);

endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; result computed at issue, retired after LAT busy cycles.
// Optional feature macro: MDU_MACC_EN (adds MADD/MADDU/MSUB/MSUBU).
module mdu_unit
   import mdu_unit_pkg::*;
#(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input logic        clk,
   input logic        reset,
   mdu_unit_if.slave  bus
);

   localparam logic [MDU_CNT_W-1:0] MUL_CNT = MDU_CNT_W'(MUL_LAT);
   localparam logic [MDU_CNT_W-1:0] DIV_CNT = MDU_CNT_W'(DIV_LAT);

   mdu_state_e           state_reg, state_next;
   logic [MDU_CNT_W-1:0] cnt_reg, cnt_next;
   logic [63:0]          res_reg, res_next;
   logic                 res_wr_reg, res_wr_next;
   logic [31:0]          hi_reg, hi_next;
   logic [31:0]          lo_reg, lo_next;

   logic [63:0]          prod_s, prod_u;
   logic [31:0]          quo_s, rem_s, quo_u, rem_u;

   logic                 issue_go;
   logic                 issue_wr;
   logic [MDU_CNT_W-1:0] issue_cnt;
   logic [63:0]          issue_res;

   // Signed divide done at 64 bits so 0x80000000 / -1 yields 0x80000000 without overflow.
   always_comb begin
      prod_s = $signed(sext64(bus.a)) * $signed(sext64(bus.b));
      prod_u = {32'd0, bus.a} * {32'd0, bus.b};
      quo_s  = '0;
      rem_s  = '0;
      quo_u  = '0;
      rem_u  = '0;
      if (bus.b != 32'd0) begin
         quo_s = 32'($signed(sext64(bus.a)) / $signed(sext64(bus.b)));
         rem_s = 32'($signed(sext64(bus.a)) % $signed(sext64(bus.b)));
         quo_u = bus.a / bus.b;
         rem_u = bus.a % bus.b;
      end
   end

   always_comb begin
      issue_go  = 1'b0;
      issue_wr  = 1'b0;
      issue_cnt = '0;
      issue_res = '0;
      case (bus.op)
         MDU_MULT:  begin issue_go = 1'b1; issue_cnt = MUL_CNT; issue_wr = 1'b1; issue_res = prod_s; end
         MDU_MULTU: begin issue_go = 1'b1; issue_cnt = MUL_CNT; issue_wr = 1'b1; issue_res = prod_u; end
         MDU_DIV:   begin
            issue_go  = 1'b1;
            issue_cnt = DIV_CNT;
            issue_wr  = (bus.b != 32'd0);
            issue_res = {rem_s, quo_s};
         end
         MDU_DIVU:  begin
            issue_go  = 1'b1;
            issue_cnt = DIV_CNT;
            issue_wr  = (bus.b != 32'd0);
            issue_res = {rem_u, quo_u};
         end
`ifdef MDU_MACC_EN
         MDU_MADD:  begin issue_go = 1'b1; issue_cnt = MUL_CNT; issue_wr = 1'b1; issue_res = {hi_reg, lo_reg} + prod_s; end
         MDU_MADDU: begin issue_go = 1'b1; issue_cnt = MUL_CNT; issue_wr = 1'b1; issue_res = {hi_reg, lo_reg} + prod_u; end
         MDU_MSUB:  begin issue_go = 1'b1; issue_cnt = MUL_CNT; issue_wr = 1'b1; issue_res = {hi_reg, lo_reg} - prod_s; end
         MDU_MSUBU: begin issue_go = 1'b1; issue_cnt = MUL_CNT; issue_wr = 1'b1; issue_res = {hi_reg, lo_reg} - prod_u; end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      res_next    = res_reg;
      res_wr_next = res_wr_reg;
      hi_next     = hi_reg;
      lo_next     = lo_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               if (issue_go) begin
                  state_next  = ST_RUN;
                  cnt_next    = issue_cnt;
                  res_next    = issue_res;
                  res_wr_next = issue_wr;
               end else if (bus.op == MDU_MTHI) begin
                  hi_next = bus.a;
               end else if (bus.op == MDU_MTLO) begin
                  lo_next = bus.a;
               end
            end
         end
         ST_RUN: begin
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == 1) begin
               state_next = ST_IDLE;
               // A divide by zero still occupies the unit but never retires a result.
               if (res_wr_reg) begin
                  hi_next = res_reg[63:32];
                  lo_next = res_reg[31:0];
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         res_reg    <= '0;
         res_wr_reg <= 1'b0;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         res_reg    <= res_next;
         res_wr_reg <= res_wr_next;
         hi_reg     <= hi_next;
         lo_reg     <= lo_next;
      end
   end

   assign bus.busy = (state_reg == ST_RUN);
   assign bus.hi   = hi_reg;
   assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, corner-case sequences, random ops vs. a reference model.
module tb_mdu_unit;
   import mdu_unit_pkg::*;

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_txn    = 0;

   mdu_unit_if bus ();

   mdu_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      tick();
      bus.start = 1'b0;
      bus.op    = MDU_NOP;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy && n < 40) begin
         tick();
         n++;
      end
   endtask

   // Reference: what a single issued op does to HI/LO, and how long the unit stays busy.
   function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi_in, input logic [31:0] lo_in,
                                  output logic [31:0] hi_out, output logic [31:0] lo_out, output int lat);
      longint          sa  = longint'(int'(a));
      longint          sb  = longint'(int'(b));
      longint unsigned ua  = longint'(a);
      longint unsigned ub  = longint'(b);
      logic [63:0]     acc = {hi_in, lo_in};
      logic [63:0]     r   = acc;
      lat = 0;
      case (op)
         MDU_MULT:  begin r = sa * sb; lat = MUL_LAT; end
         MDU_MULTU: begin r = ua * ub; lat = MUL_LAT; end
         MDU_DIV:   begin
            lat = DIV_LAT;
            if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
         end
         MDU_DIVU:  begin
            lat = DIV_LAT;
            if (b != 0) r = {32'(ua % ub), 32'(ua / ub)};
         end
         MDU_MTHI:  r = {a, lo_in};
         MDU_MTLO:  r = {hi_in, a};
`ifdef MDU_MACC_EN
         MDU_MADD:  begin r = acc + 64'(sa * sb); lat = MUL_LAT; end
         MDU_MADDU: begin r = acc + 64'(ua * ub); lat = MUL_LAT; end
         MDU_MSUB:  begin r = acc - 64'(sa * sb); lat = MUL_LAT; end
         MDU_MSUBU: begin r = acc - 64'(ua * ub); lat = MUL_LAT; end
`endif
         default: ;
      endcase
      hi_out = r[63:32];
      lo_out = r[31:0];
   endfunction

   initial begin
      int          n, m;
      logic [3:0]  op;
      logic [31:0] a, b, mhi, mlo, nhi, nlo;
      int          lat;

      vecs[0] = '{MDU_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT};
      vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, MUL_LAT};
      vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
      vecs[3] = '{MDU_DIVU,  32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003, DIV_LAT};
      vecs[4] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT};
      vecs[5] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT};
      vecs[6] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT};
      vecs[7] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = MDU_NOP;
      bus.a     = '0;
      bus.b     = '0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_hi", bus.hi, 32'd0);
      check("reset_lo", bus.lo, 32'd0);

      // Reset held three cycles mid-operation aborts it.
      issue(MDU_MULT, 32'd2, 32'd3);
      tick();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_hi", bus.hi, 32'd0);
      check("abort_lo", bus.lo, 32'd0);
      repeat (MUL_LAT) tick();
      check("abort_discard_lo", bus.lo, 32'd0);
      $display("txn %0d: reset mid-op -> busy=%0d hi=%h lo=%h", n_txn++, bus.busy, bus.hi, bus.lo);

      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_idle(n);
         check($sformatf("vec%0d_lat", i), 32'(n), 32'(vecs[i].lat));
         check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
         $display("txn %0d: op=%0d a=%h b=%h busy=%0d hi=%h lo=%h",
                  n_txn++, vecs[i].op, vecs[i].a, vecs[i].b, n, bus.hi, bus.lo);
      end

      // MTHI/MTLO are single-cycle; divide by zero keeps HI/LO; MTLO while busy is dropped.
      issue(MDU_MTHI, 32'h0000_1234, 32'd0);
      check("mthi_busy", 32'(bus.busy), 32'd0);
      check("mthi_hi", bus.hi, 32'h0000_1234);
      issue(MDU_MTLO, 32'h5555_AAAA, 32'd0);
      check("mtlo_lo", bus.lo, 32'h5555_AAAA);
      issue(MDU_DIV, 32'd5, 32'd0);
      issue(MDU_MTLO, 32'h0000_DEAD, 32'd0);
      wait_idle(m);
      check("div0_lat", 32'(m + 1), 32'(DIV_LAT));
      check("div0_hi", bus.hi, 32'h0000_1234);
      check("div0_lo", bus.lo, 32'h5555_AAAA);
      $display("txn %0d: div by zero + mtlo while busy -> busy=%0d hi=%h lo=%h", n_txn++, m + 1, bus.hi, bus.lo);

      // A second start during busy cycle 2 is ignored.
      issue(MDU_MULT, 32'd2, 32'd3);
      tick();
      issue(MDU_DIV, 32'd9, 32'd3);
      wait_idle(m);
      check("overlap_lat", 32'(m + 2), 32'(MUL_LAT));
      check("overlap_hi", bus.hi, 32'd0);
      check("overlap_lo", bus.lo, 32'd6);
      $display("txn %0d: mult with ignored div -> busy=%0d hi=%h lo=%h", n_txn++, m + 2, bus.hi, bus.lo);

      issue(MDU_MTHI, 32'd0, 32'd0);
      issue(MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
      issue(MDU_MADDU, 32'd1, 32'd1);
      wait_idle(n);
`ifdef MDU_MACC_EN
      check("maddu_lat", 32'(n), 32'(MUL_LAT));
      check("maddu_hi", bus.hi, 32'd1);
      check("maddu_lo", bus.lo, 32'd0);
`else
      check("maddu_lat", 32'(n), 32'd0);
      check("maddu_hi", bus.hi, 32'd0);
      check("maddu_lo", bus.lo, 32'hFFFF_FFFF);
`endif
      $display("txn %0d: maddu 1*1 -> busy=%0d hi=%h lo=%h", n_txn++, n, bus.hi, bus.lo);

      issue(4'hF, 32'h1111_1111, 32'h2222_2222);
      wait_idle(n);
      check("undef_busy", 32'(n), 32'd0);
      check("undef_lo", bus.lo, 32'hFFFF_FFFF);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      mhi = '0;
      mlo = '0;
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 11));
         if (op == 4'd11) op = 4'hF;
         a = $urandom;
         b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         if ($urandom_range(0, 15) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         ref_op(op, a, b, mhi, mlo, nhi, nlo, lat);
         issue(op, a, b);
         wait_idle(n);
         check($sformatf("rnd%0d_lat", i), 32'(n), 32'(lat));
         check($sformatf("rnd%0d_hi", i), bus.hi, nhi);
         check($sformatf("rnd%0d_lo", i), bus.lo, nlo);
         mhi = nhi;
         mlo = nlo;
         $display("txn %0d: op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", n_txn++, op, a, b, n, bus.hi, bus.lo);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
